// File: rtl/rv32_pkg.sv
// Shared types, encodings and immediate helpers for the RV32I + Zicsr decode/execute stage.
package rv32_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS2, ALU_ANDN
    } alu_cmd_t;

    typedef enum logic [2:0] {
        WB_NONE = 3'd0, WB_ALU = 3'd1, WB_MEM = 3'd2, WB_PC4 = 3'd3, WB_CSR = 3'd4
    } wb_sel_t;

    typedef enum logic [1:0] {
        MW_BYTE = 2'b00, MW_HALF = 2'b01, MW_WORD = 2'b10
    } mem_width_t;

    typedef struct packed {
        logic [4:0]  rd_addr;
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [31:0] pc_plus_4;
        logic [31:0] pc_branch;
        logic        is_jump;
        wb_sel_t     wb_sel;
        logic        csr_wb_en;
        logic        read_enable;
        logic        write_enable;
        mem_width_t  wstrb;
        logic [31:0] wb_mask;
        logic        load_signed;
        logic        ebreak;
        logic        illegal_instr;
    } stage_out_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0]  F7_BASE      = 7'b0000000;
    localparam logic [6:0]  F7_ALT       = 7'b0100000;
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    function automatic logic [31:0] imm_i(input logic [31:0] i);
        return {{20{i[31]}}, i[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] i);
        return {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] i);
        return {i[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // OP and OP-IMM share one funct3 table; alt selects SUB/SRA.
    function automatic alu_cmd_t arith_cmd(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            3'd7:    return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32I ALU, extended with the pass/and-not operations CSR updates need.
module rv32_alu
    import rv32_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  alu_cmd_t    alu_cmd,
    output logic [31:0] result
);

    // Result select.
    always_comb begin
        result = 32'h0;
        case (alu_cmd)
            ALU_ADD:   result = op1 + op2;
            ALU_SUB:   result = op1 - op2;
            ALU_SLL:   result = op1 << op2[4:0];
            ALU_SLT:   result = {31'h0, $signed(op1) < $signed(op2)};
            ALU_SLTU:  result = {31'h0, op1 < op2};
            ALU_XOR:   result = op1 ^ op2;
            ALU_SRL:   result = op1 >> op2[4:0];
            ALU_SRA:   result = 32'($signed(op1) >>> op2[4:0]);
            ALU_OR:    result = op1 | op2;
            ALU_AND:   result = op1 & op2;
            ALU_PASS2: result = op2;
            ALU_ANDN:  result = op1 & ~op2;
            default:   result = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32_decode_exec_mem.sv
// Decode, operand select, ALU, next-PC and data-memory controls for one instruction;
// register/CSR read addresses are combinational, everything else is registered once.
module rv32_decode_exec_mem
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] reg_rs1,
    input  logic [XLEN-1:0] reg_rs2,
    input  logic [XLEN-1:0] csr_data,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [11:0]     csr_addr,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] pc_plus_4,
    output logic [XLEN-1:0] pc_branch,
    output logic            is_jump,
    output logic [2:0]      wb_sel,
    output logic            csr_wb_en,
    output logic            read_enable,
    output logic            write_enable,
    output logic [1:0]      write_wstrb,
    output logic [XLEN-1:0] wb_mask,
    output logic            load_signed,
    output logic            ebreak,
    output logic            illegal_instr
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] op1_s;
    logic [31:0] op2_s;
    logic [31:0] alu_res_s;
    logic [31:0] target_s;
    alu_cmd_t    alu_cmd_s;
    wb_sel_t     wb_sel_s;
    mem_width_t  width_s;
    logic [31:0] mask_s;
    logic        read_en_s, write_en_s, load_signed_s, csr_wb_s, take_s, ebreak_s, illegal_s;
    stage_out_t  out_d, out_q;

    assign opcode_s = instruction[6:0];
    assign funct3_s = instruction[14:12];
    assign funct7_s = instruction[31:25];
    assign rs1_addr = instruction[19:15];
    assign rs2_addr = instruction[24:20];
    assign csr_addr = instruction[31:20];

    rv32_alu u_alu (
        .op1     (op1_s),
        .op2     (op2_s),
        .alu_cmd (alu_cmd_s),
        .result  (alu_res_s)
    );

    // Instruction decode: operand muxing, ALU command, control intent and legality.
    always_comb begin
        op1_s         = reg_rs1;
        op2_s         = imm_i(instruction);
        alu_cmd_s     = ALU_ADD;
        wb_sel_s      = WB_NONE;
        read_en_s     = 1'b0;
        write_en_s    = 1'b0;
        width_s       = MW_BYTE;
        mask_s        = 32'h0;
        load_signed_s = 1'b0;
        csr_wb_s      = 1'b0;
        take_s        = 1'b0;
        ebreak_s      = 1'b0;
        illegal_s     = 1'b0;
        target_s      = pc + imm_b(instruction);
        case (opcode_s)
            OPC_OP: begin
                op2_s     = reg_rs2;
                wb_sel_s  = WB_ALU;
                alu_cmd_s = arith_cmd(funct3_s, funct7_s[5]);
                illegal_s = !((funct7_s == F7_BASE) ||
                              ((funct7_s == F7_ALT) && ((funct3_s == 3'd0) || (funct3_s == 3'd5))));
            end
            OPC_OPIMM: begin
                wb_sel_s  = WB_ALU;
                alu_cmd_s = arith_cmd(funct3_s, (funct3_s == 3'd5) && funct7_s[5]);
                if (funct3_s == 3'd1) begin
                    illegal_s = (funct7_s != F7_BASE);
                end else if (funct3_s == 3'd5) begin
                    illegal_s = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OPC_LUI: begin
                op1_s    = 32'h0;
                op2_s    = imm_u(instruction);
                wb_sel_s = WB_ALU;
            end
            OPC_AUIPC: begin
                op1_s    = pc;
                op2_s    = imm_u(instruction);
                wb_sel_s = WB_ALU;
            end
            OPC_LOAD: begin
                read_en_s = 1'b1;
                wb_sel_s  = WB_MEM;
                case (funct3_s)
                    3'd0:    begin width_s = MW_BYTE; mask_s = 32'h0000_00FF; load_signed_s = 1'b1; end
                    3'd1:    begin width_s = MW_HALF; mask_s = 32'h0000_FFFF; load_signed_s = 1'b1; end
                    3'd2:    begin width_s = MW_WORD; mask_s = 32'hFFFF_FFFF; load_signed_s = 1'b1; end
                    3'd4:    begin width_s = MW_BYTE; mask_s = 32'h0000_00FF; end
                    3'd5:    begin width_s = MW_HALF; mask_s = 32'h0000_FFFF; end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_STORE: begin
                op2_s      = imm_s(instruction);
                write_en_s = 1'b1;
                case (funct3_s)
                    3'd0:    width_s = MW_BYTE;
                    3'd1:    width_s = MW_HALF;
                    3'd2:    width_s = MW_WORD;
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3_s)
                    3'd0:    take_s = (reg_rs1 == reg_rs2);
                    3'd1:    take_s = (reg_rs1 != reg_rs2);
                    3'd4:    take_s = ($signed(reg_rs1) < $signed(reg_rs2));
                    3'd5:    take_s = ($signed(reg_rs1) >= $signed(reg_rs2));
                    3'd6:    take_s = (reg_rs1 < reg_rs2);
                    3'd7:    take_s = (reg_rs1 >= reg_rs2);
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_JAL: begin
                take_s   = 1'b1;
                wb_sel_s = WB_PC4;
                target_s = pc + imm_j(instruction);
            end
            OPC_JALR: begin
                take_s    = 1'b1;
                wb_sel_s  = WB_PC4;
                target_s  = (reg_rs1 + imm_i(instruction)) & ~32'h1;
                illegal_s = (funct3_s != 3'd0);
            end
            OPC_SYSTEM: begin
                case (funct3_s)
                    3'd0: begin
                        ebreak_s  = (instruction == INSTR_EBREAK);
                        illegal_s = !((instruction == INSTR_ECALL) || (instruction == INSTR_EBREAK));
                    end
                    3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7: begin
                        // Immediate forms take the rs1 field itself, zero-extended.
                        op1_s     = csr_data;
                        op2_s     = funct3_s[2] ? {27'h0, instruction[19:15]} : reg_rs1;
                        alu_cmd_s = (funct3_s[1:0] == 2'b01) ? ALU_PASS2 :
                                    (funct3_s[1:0] == 2'b10) ? ALU_OR : ALU_ANDN;
                        wb_sel_s  = WB_CSR;
                        csr_wb_s  = (funct3_s[1:0] == 2'b01) || (instruction[19:15] != 5'd0);
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OPC_MISC_MEM: illegal_s = (funct3_s != 3'd0);
            default:      illegal_s = 1'b1;
        endcase
    end

    // Next register contents; an illegal encoding suppresses every side effect.
    always_comb begin
        out_d               = '0;
        out_d.rd_addr       = instruction[11:7];
        out_d.alu_out       = alu_res_s;
        out_d.store_data    = reg_rs2;
        out_d.pc_plus_4     = pc + 32'd4;
        out_d.pc_branch     = target_s;
        out_d.ebreak        = ebreak_s;
        out_d.illegal_instr = illegal_s;
        if (illegal_s) begin
            out_d.wb_sel = WB_NONE;
        end else begin
            out_d.wb_sel       = wb_sel_s;
            out_d.is_jump      = take_s;
            out_d.csr_wb_en    = csr_wb_s;
            out_d.read_enable  = read_en_s;
            out_d.write_enable = write_en_s;
            out_d.wstrb        = width_s;
            out_d.wb_mask      = mask_s;
            out_d.load_signed  = load_signed_s;
        end
    end

    // Output register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign rd_addr       = out_q.rd_addr;
    assign alu_out       = out_q.alu_out;
    assign store_data    = out_q.store_data;
    assign pc_plus_4     = out_q.pc_plus_4;
    assign pc_branch     = out_q.pc_branch;
    assign is_jump       = out_q.is_jump;
    assign wb_sel        = out_q.wb_sel;
    assign csr_wb_en     = out_q.csr_wb_en;
    assign read_enable   = out_q.read_enable;
    assign write_enable  = out_q.write_enable;
    assign write_wstrb   = out_q.wstrb;
    assign wb_mask       = out_q.wb_mask;
    assign load_signed   = out_q.load_signed;
    assign ebreak        = out_q.ebreak;
    assign illegal_instr = out_q.illegal_instr;

endmodule

// File: tb/tb_rv32_decode_exec_mem.sv
// Directed, table-driven bench for rv32_decode_exec_mem with hand-computed expectations.
module tb_rv32_decode_exec_mem;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] instruction, pc, reg_rs1, reg_rs2, csr_data;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [11:0] csr_addr;
    logic [31:0] alu_out, store_data, pc_plus_4, pc_branch, wb_mask;
    logic        is_jump, csr_wb_en, read_enable, write_enable, load_signed, ebreak, illegal_instr;
    logic [2:0]  wb_sel;
    logic [1:0]  write_wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rv32_decode_exec_mem dut (
        .clock(clock), .reset_n(reset_n), .instruction(instruction), .pc(pc),
        .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .csr_data(csr_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .csr_addr(csr_addr), .rd_addr(rd_addr),
        .alu_out(alu_out), .store_data(store_data), .pc_plus_4(pc_plus_4), .pc_branch(pc_branch),
        .is_jump(is_jump), .wb_sel(wb_sel), .csr_wb_en(csr_wb_en), .read_enable(read_enable),
        .write_enable(write_enable), .write_wstrb(write_wstrb), .wb_mask(wb_mask),
        .load_signed(load_signed), .ebreak(ebreak), .illegal_instr(illegal_instr)
    );

    typedef struct {
        logic [31:0] instr, pc, rs1, rs2, csr;
        logic [31:0] alu;   logic chk_alu;
        logic [2:0]  wb;    logic re, we; logic [1:0] wstrb; logic [31:0] mask; logic lsg;
        logic        jump;  logic [31:0] pcb; logic chk_pcb;
        logic        csrwb, ebrk, ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
        instruction = i; pc = p; reg_rs1 = a; reg_rs2 = b; csr_data = c;
    endtask

    initial begin
        // instr, pc, rs1, rs2, csr | alu, chk | wb, re, we, wstrb, mask, lsg | jump, pcb, chk | csrwb, ebrk, ill
        vecs.push_back('{32'hFFF00093, 32'h0,   32'h0,        32'h0,        32'h0,  32'hFFFFFFFF, 1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // ADDI -1
        vecs.push_back('{32'h402081B3, 32'h0,   32'h5,        32'h7,        32'h0,  32'hFFFFFFFE, 1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // SUB
        vecs.push_back('{32'h4020D1B3, 32'h0,   32'h80000000, 32'h4,        32'h0,  32'hF8000000, 1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // SRA
        vecs.push_back('{32'h0020B1B3, 32'h0,   32'h1,        32'hFFFFFFFF, 32'h0,  32'h1,        1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // SLTU
        vecs.push_back('{32'h0020A1B3, 32'h0,   32'hFFFFFFFF, 32'h1,        32'h0,  32'h1,        1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // SLT
        vecs.push_back('{32'h002091B3, 32'h0,   32'h1,        32'h23,       32'h0,  32'h8,        1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // SLL by 3
        vecs.push_back('{32'h00209283, 32'h0,   32'h100,      32'h0,        32'h0,  32'h102,      1'b1, 3'd2, 1'b1, 1'b0, 2'd1, 32'h0000FFFF, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // LH
        vecs.push_back('{32'hFFF0C283, 32'h0,   32'h101,      32'h0,        32'h0,  32'h100,      1'b1, 3'd2, 1'b1, 1'b0, 2'd0, 32'h000000FF, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // LBU -1
        vecs.push_back('{32'h00208023, 32'h0,   32'h200,      32'hA5A5A5A5, 32'h0,  32'h200,      1'b1, 3'd0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // SB
        vecs.push_back('{32'h0020A223, 32'h0,   32'h10,       32'h12345678, 32'h0,  32'h14,       1'b1, 3'd0, 1'b0, 1'b1, 2'd2, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // SW +4
        vecs.push_back('{32'hFE209CE3, 32'h40,  32'h1,        32'h2,        32'h0,  32'h0,        1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 32'h38,  1'b1, 1'b0, 1'b0, 1'b0}); // BNE taken
        vecs.push_back('{32'hFE209CE3, 32'h40,  32'h3,        32'h3,        32'h0,  32'h0,        1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h38,  1'b1, 1'b0, 1'b0, 1'b0}); // BNE not
        vecs.push_back('{32'h0020F463, 32'h40,  32'h1,        32'hFFFFFFFF, 32'h0,  32'h0,        1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h48,  1'b1, 1'b0, 1'b0, 1'b0}); // BGEU not
        vecs.push_back('{32'h000080E7, 32'h80,  32'h101,      32'h0,        32'h0,  32'h0,        1'b0, 3'd3, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0}); // JALR
        vecs.push_back('{32'h010000EF, 32'h100, 32'h0,        32'h0,        32'h0,  32'h0,        1'b0, 3'd3, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b1, 32'h110, 1'b1, 1'b0, 1'b0, 1'b0}); // JAL +16
        vecs.push_back('{32'h12345137, 32'h0,   32'h0,        32'h0,        32'h0,  32'h12345000, 1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // LUI
        vecs.push_back('{32'h00001117, 32'h1000,32'h0,        32'h0,        32'h0,  32'h2000,     1'b1, 3'd1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // AUIPC
        vecs.push_back('{32'h3000A2F3, 32'h0,   32'h0F,       32'h0,        32'hF0, 32'hFF,       1'b1, 3'd4, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0}); // CSRRS
        vecs.push_back('{32'h300022F3, 32'h0,   32'h0,        32'h0,        32'hF0, 32'hF0,       1'b1, 3'd4, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0}); // CSRRS x0
        vecs.push_back('{32'h3000B2F3, 32'h0,   32'h0F,       32'h0,        32'hFF, 32'hF0,       1'b1, 3'd4, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0}); // CSRRC
        vecs.push_back('{32'h3002D2F3, 32'h0,   32'hDEAD,     32'h0,        32'h77, 32'h5,        1'b1, 3'd4, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 1'b0}); // CSRRWI 5
        vecs.push_back('{32'h00100073, 32'h0,   32'h0,        32'h0,        32'h0,  32'h0,        1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0}); // EBREAK
        vecs.push_back('{32'h020081B3, 32'h0,   32'h3,        32'h4,        32'h0,  32'h0,        1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1}); // MUL: illegal
        vecs.push_back('{32'hFFFFFFFF, 32'h0,   32'h0,        32'h0,        32'h0,  32'h0,        1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1}); // all ones

        // Reset held with a live ADD x3,x1,x2: every registered output must stay 0.
        reset_n = 1'b0;
        drive(32'h002081B3, 32'h40, 32'h5, 32'h7, 32'h0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst alu_out", alu_out, 32'h0);
        chk("rst rd_addr", {27'h0, rd_addr}, 32'h0);
        chk("rst pc_plus_4", pc_plus_4, 32'h0);
        chk("rst store_data", store_data, 32'h0);
        chk("rst ctrl", {25'h0, wb_sel, is_jump, read_enable, write_enable, illegal_instr}, 32'h0);
        chk("rs1_addr comb", {27'h0, rs1_addr}, 32'h1);
        chk("rs2_addr comb", {27'h0, rs2_addr}, 32'h2);

        // Release: result of the same ADD appears after one edge.
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("post-rst alu_out", alu_out, 32'hC);
        chk("post-rst rd_addr", {27'h0, rd_addr}, 32'h3);
        chk("post-rst wb_sel", {29'h0, wb_sel}, 32'h1);
        chk("post-rst pc_plus_4", pc_plus_4, 32'h44);

        // Latency: new inputs must not reach the outputs before the next edge.
        drive(32'hFFF00093, 32'h0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("latency hold", alu_out, 32'hC);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].csr);
            @(posedge clock); #1;
            chk($sformatf("v%0d rd_addr", i), {27'h0, rd_addr}, {27'h0, vecs[i].instr[11:7]});
            chk($sformatf("v%0d wb_sel", i), {29'h0, wb_sel}, {29'h0, vecs[i].wb});
            chk($sformatf("v%0d re/we", i), {30'h0, read_enable, write_enable}, {30'h0, vecs[i].re, vecs[i].we});
            chk($sformatf("v%0d mask", i), wb_mask, vecs[i].mask);
            chk($sformatf("v%0d load_signed", i), {31'h0, load_signed}, {31'h0, vecs[i].lsg});
            chk($sformatf("v%0d is_jump", i), {31'h0, is_jump}, {31'h0, vecs[i].jump});
            chk($sformatf("v%0d csr_wb_en", i), {31'h0, csr_wb_en}, {31'h0, vecs[i].csrwb});
            chk($sformatf("v%0d ebreak", i), {31'h0, ebreak}, {31'h0, vecs[i].ebrk});
            chk($sformatf("v%0d illegal", i), {31'h0, illegal_instr}, {31'h0, vecs[i].ill});
            chk($sformatf("v%0d store_data", i), store_data, vecs[i].rs2);
            chk($sformatf("v%0d pc_plus_4", i), pc_plus_4, vecs[i].pc + 32'd4);
            if (vecs[i].chk_alu) chk($sformatf("v%0d alu_out", i), alu_out, vecs[i].alu);
            if (vecs[i].chk_pcb) chk($sformatf("v%0d pc_branch", i), pc_branch, vecs[i].pcb);
            if (vecs[i].re || vecs[i].we) chk($sformatf("v%0d wstrb", i), {30'h0, write_wstrb}, {30'h0, vecs[i].wstrb});
        end

        // CSR address decode is combinational.
        drive(32'h3000A2F3, 32'h0, 32'h0F, 32'h0, 32'hF0);
        #1;
        chk("csr_addr comb", {20'h0, csr_addr}, 32'h300);

        // Back-to-back: taken branch then equal operands; each edge reflects only its own inputs.
        drive(32'hFE209CE3, 32'h40, 32'h1, 32'h2, 32'h0);
        @(posedge clock); #1;
        chk("seq bne taken", {31'h0, is_jump}, 32'h1);
        drive(32'hFE209CE3, 32'h40, 32'h9, 32'h9, 32'h0);
        @(posedge clock); #1;
        chk("seq bne equal", {31'h0, is_jump}, 32'h0);

        // Reset asserted mid-stream clears a pending load request.
        drive(32'h00209283, 32'h0, 32'h100, 32'h0, 32'h0);
        @(posedge clock); #1;
        chk("seq load re", {31'h0, read_enable}, 32'h1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("seq rst re", {31'h0, read_enable}, 32'h0);
        chk("seq rst mask", wb_mask, 32'h0);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
